// File: rtl/fir_result_framer_if.sv
// Handshake/data bundle between the FIR accumulator, the result framer and the SPI slave.
// The master side produces result blocks and packet boundaries; the slave side is the framer.
interface fir_result_framer_if #(
    parameter int unsigned SAMPLES_NUM  = 2,
    parameter int unsigned ACC_WIDTH    = 32,
    parameter int unsigned PACKET_BYTES = 8
);
    logic                               result_valid;
    logic [ACC_WIDTH*SAMPLES_NUM-1:0]   result_data;
    logic                               packet_done;
    logic                               clear_flags;
    logic [PACKET_BYTES*8-1:0]          tx_data;
    logic                               ready;
    logic                               busy;
    logic                               overrun;
    logic                               underrun;
    logic [15:0]                        sat_count;

    modport master (
        output result_valid, result_data, packet_done, clear_flags,
        input  tx_data, ready, busy, overrun, underrun, sat_count
    );

    modport slave (
        input  result_valid, result_data, packet_done, clear_flags,
        output tx_data, ready, busy, overrun, underrun, sat_count
    );
endinterface

// File: rtl/fir_result_framer.sv
// Captures a block of wide FIR results, rounds/shifts/saturates one sample per clock into a
// packet-wide staging word, and hands it to the SPI transmit path on each packet boundary.
module fir_result_framer #(
    parameter int unsigned SAMPLES_NUM  = 2,
    parameter int unsigned ACC_WIDTH    = 32,
    parameter int unsigned OUT_WIDTH    = 16,
    parameter int unsigned SHIFT        = 8,
    parameter int unsigned PACKET_BYTES = 8
) (
    input logic               clk,
    input logic               rst,
    fir_result_framer_if.slave bus
);
    localparam int unsigned P    = PACKET_BYTES * 8;
    localparam int unsigned IdxW = (SAMPLES_NUM > 1) ? $clog2(SAMPLES_NUM) : 1;
    // Half an LSB of the shifted result; zero when no shift is applied.
    localparam logic signed [ACC_WIDTH:0] RndVal = ((ACC_WIDTH + 1)'(1) << SHIFT) >> 1;
    localparam logic signed [ACC_WIDTH:0] MaxVal =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] MinVal =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StScale, StReady} state_e;

    state_e                           state_q, state_d;
    logic [ACC_WIDTH*SAMPLES_NUM-1:0] in_q, in_d;
    logic [IdxW-1:0]                  idx_q, idx_d;
    logic [P-1:0]                     staging_q, staging_d;
    logic [P-1:0]                     tx_q, tx_d;
    logic                             overrun_q, overrun_d;
    logic                             underrun_q, underrun_d;
    logic [15:0]                      sat_q, sat_d, sat_base;

    logic [ACC_WIDTH-1:0]             sample;
    logic signed [ACC_WIDTH:0]        rounded, shifted;
    logic                             clip_hi, clip_lo;
    logic [OUT_WIDTH-1:0]             sat_val;

    // One extra bit keeps the rounding add from wrapping.
    always_comb begin
        sample = '0;
        for (int i = 0; i < SAMPLES_NUM; i++) begin
            if (idx_q == IdxW'(i)) sample = in_q[i*ACC_WIDTH +: ACC_WIDTH];
        end
        rounded = {sample[ACC_WIDTH-1], sample} + RndVal;
        shifted = rounded >>> SHIFT;
        clip_hi = shifted > MaxVal;
        clip_lo = shifted < MinVal;
        if (clip_hi)      sat_val = MaxVal[OUT_WIDTH-1:0];
        else if (clip_lo) sat_val = MinVal[OUT_WIDTH-1:0];
        else              sat_val = shifted[OUT_WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        in_d       = in_q;
        idx_d      = idx_q;
        staging_d  = staging_q;
        tx_d       = tx_q;
        overrun_d  = bus.clear_flags ? 1'b0 : overrun_q;
        underrun_d = bus.clear_flags ? 1'b0 : underrun_q;
        sat_base   = bus.clear_flags ? 16'd0 : sat_q;
        sat_d      = sat_base;

        if (bus.packet_done) begin
            if (state_q == StReady) begin
                tx_d = staging_q;
            end else begin
                tx_d       = '0;
                underrun_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.result_valid) begin
                    in_d    = bus.result_data;
                    idx_d   = '0;
                    state_d = StScale;
                end
            end
            StScale: begin
                // Sample 0 lands in the MSBs so it is shifted out first.
                for (int i = 0; i < SAMPLES_NUM; i++) begin
                    if (idx_q == IdxW'(i)) staging_d[P-1-i*OUT_WIDTH -: OUT_WIDTH] = sat_val;
                end
                if ((clip_hi || clip_lo) && sat_base != 16'hFFFF) sat_d = sat_base + 16'd1;
                if (idx_q == IdxW'(SAMPLES_NUM - 1)) state_d = StReady;
                else                                 idx_d   = idx_q + IdxW'(1);
                if (bus.result_valid) overrun_d = 1'b1;
            end
            StReady: begin
                if (bus.packet_done) begin
                    if (bus.result_valid) begin
                        in_d    = bus.result_data;
                        idx_d   = '0;
                        state_d = StScale;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (bus.result_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            in_q       <= '0;
            idx_q      <= '0;
            staging_q  <= '0;
            tx_q       <= '0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            sat_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_q       <= in_d;
            idx_q      <= idx_d;
            staging_q  <= staging_d;
            tx_q       <= tx_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
            sat_q      <= sat_d;
        end
    end

    assign bus.tx_data   = tx_q;
    assign bus.ready     = (state_q == StReady);
    assign bus.busy      = (state_q == StScale);
    assign bus.overrun   = overrun_q;
    assign bus.underrun  = underrun_q;
    assign bus.sat_count = sat_q;
endmodule

// File: tb/tb_fir_result_framer.sv
// Randomized bench for fir_result_framer: a default-parameter instance plus an 8-sample,
// 8-bit, no-shift instance, both checked against arithmetic reference scaling.
module tb_fir_result_framer;
    localparam int SN = 2, AW = 32, OW = 16, SH = 8, PB = 8;

    typedef logic [31:0] blk_t [8];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    fir_result_framer_if #(.SAMPLES_NUM(SN), .ACC_WIDTH(AW), .PACKET_BYTES(PB)) bus ();
    fir_result_framer_if #(.SAMPLES_NUM(8), .ACC_WIDTH(32), .PACKET_BYTES(8)) bus8 ();

    fir_result_framer #(
        .SAMPLES_NUM(SN), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(SH), .PACKET_BYTES(PB)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    fir_result_framer #(
        .SAMPLES_NUM(8), .ACC_WIDTH(32), .OUT_WIDTH(8), .SHIFT(0), .PACKET_BYTES(8)
    ) dut8 (
        .clk(clk), .rst(rst), .bus(bus8)
    );

    // Reference: round half-up, arithmetic shift, clamp to the signed output range.
    function automatic longint ref_scale(input longint s, input int sh, input int ow,
                                         output bit clip);
        longint r, q, hi, lo;
        r = s;
        if (sh > 0) r = r + (longint'(1) << (sh - 1));
        q = r >>> sh;
        hi = (longint'(1) << (ow - 1)) - 1;
        lo = -hi - 1;
        clip = (q > hi) || (q < lo);
        if (q > hi) q = hi;
        else if (q < lo) q = lo;
        return q;
    endfunction

    function automatic logic [63:0] ref_block(input blk_t smp, input int n, input int sh,
                                              input int ow, output int clips);
        logic [63:0] w;
        longint      v;
        bit          c;
        w = '0;
        clips = 0;
        for (int k = 0; k < n; k++) begin
            v = ref_scale(longint'($signed(smp[k])), sh, ow, c);
            if (c) clips++;
            w = w | ((64'(v) & ((64'd1 << ow) - 64'd1)) << (64 - (k + 1) * ow));
        end
        return w;
    endfunction

    function automatic logic [31:0] gen_sample();
        logic [23:0] t;
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: begin t = 24'($urandom); return {{8{t[23]}}, t}; end
            2: begin
                case ($urandom_range(0, 3))
                    0: return 32'h007F_FF7F;
                    1: return 32'h007F_FF80;
                    2: return 32'hFF80_0000;
                    default: return 32'hFF7F_FF7F;
                endcase
            end
            default: return 32'($urandom_range(0, 65535)) - 32'd32768;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input blk_t smp);
        for (int k = 0; k < SN; k++) bus.result_data[k*AW +: AW] = smp[k];
        bus.result_valid = 1'b1;
        step();
        bus.result_valid = 1'b0;
    endtask

    task automatic packet_done();
        bus.packet_done = 1'b1;
        step();
        bus.packet_done = 1'b0;
    endtask

    task automatic clear_flags();
        bus.clear_flags = 1'b1;
        step();
        bus.clear_flags = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.ready && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (bus.ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready timeout: got %b want 1", tag, bus.ready);
        end
    endtask

    task automatic test_reset();
        blk_t b;
        int   c;
        logic [63:0] e;
        b = '{default: 32'h0};
        b[0] = 32'h1234_5678;
        b[1] = 32'hFFFF_0000;
        e = ref_block(b, SN, SH, OW, c);
        pulse(b);
        wait_ready("reset_pre");
        packet_done();
        vectors++;
        if (bus.tx_data !== e) begin
            miscompares++;
            $display("FAIL reset_pre_tx: got %h want %h", bus.tx_data, e);
        end
        b[0] = 32'h7FFF_FFFF;
        pulse(b);
        pulse(b);  // lands in SCALE: dropped, overrun
        rst = 1'b1;
        #2;
        vectors++;
        if ({bus.tx_data, bus.ready, bus.busy, bus.overrun, bus.underrun, bus.sat_count} !== '0)
        begin
            miscompares++;
            $display("FAIL reset_outputs: got tx=%h rdy=%b busy=%b ovr=%b und=%b sat=%0d want all 0",
                     bus.tx_data, bus.ready, bus.busy, bus.overrun, bus.underrun, bus.sat_count);
        end
        step();
        rst = 1'b0;
        repeat (4) step();
        vectors++;
        if (bus.ready !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_abandon: got rdy=%b busy=%b want 0 0", bus.ready, bus.busy);
        end
        packet_done();
        vectors++;
        if (bus.tx_data !== 64'h0 || bus.underrun !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_underrun: got tx=%h und=%b want 0 1", bus.tx_data, bus.underrun);
        end
        clear_flags();
        vectors++;
        if (bus.underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_underrun: got %b want 0", bus.underrun);
        end
    endtask

    task automatic test_rounding();
        blk_t b;
        int   c;
        logic [63:0] e;
        b = '{default: 32'h0};
        b[0] = 32'h0000_1280;
        b[1] = 32'hFFFF_FE80;
        e = ref_block(b, SN, SH, OW, c);
        pulse(b);
        vectors++;
        if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
            miscompares++;
            $display("FAIL round_t0: got busy=%b rdy=%b want 1 0", bus.busy, bus.ready);
        end
        step();
        vectors++;
        if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
            miscompares++;
            $display("FAIL round_t1: got busy=%b rdy=%b want 1 0", bus.busy, bus.ready);
        end
        step();
        vectors++;
        if (bus.busy !== 1'b0 || bus.ready !== 1'b1) begin
            miscompares++;
            $display("FAIL round_t2: got busy=%b rdy=%b want 0 1", bus.busy, bus.ready);
        end
        packet_done();
        vectors++;
        if (bus.tx_data !== 64'h0013_FFFF_0000_0000 || bus.tx_data !== e) begin
            miscompares++;
            $display("FAIL round_tx: got %h want %h", bus.tx_data, 64'h0013_FFFF_0000_0000);
        end
    endtask

    task automatic test_saturation();
        blk_t b;
        b = '{default: 32'h0};
        clear_flags();
        b[0] = 32'h7FFF_FFFF;
        b[1] = 32'h8000_0000;
        pulse(b);
        wait_ready("sat_a");
        packet_done();
        vectors++;
        if (bus.tx_data !== 64'h7FFF_8000_0000_0000 || bus.sat_count !== 16'd2) begin
            miscompares++;
            $display("FAIL sat_clip: got tx=%h sat=%0d want 7fff800000000000 2",
                     bus.tx_data, bus.sat_count);
        end
        b[0] = 32'h0000_0100;
        b[1] = 32'hFFFF_FF00;
        pulse(b);
        wait_ready("sat_b");
        packet_done();
        vectors++;
        if (bus.sat_count !== 16'd2 || bus.tx_data !== 64'h0001_FFFF_0000_0000) begin
            miscompares++;
            $display("FAIL sat_hold: got tx=%h sat=%0d want 0001ffff00000000 2",
                     bus.tx_data, bus.sat_count);
        end
        clear_flags();
        vectors++;
        if (bus.sat_count !== 16'd0) begin
            miscompares++;
            $display("FAIL sat_clear: got %0d want 0", bus.sat_count);
        end
    endtask

    task automatic test_underrun_mid_scale();
        blk_t b;
        int   c;
        logic [63:0] e;
        b = '{default: 32'h0};
        clear_flags();
        b[0] = 32'h0001_2300;
        b[1] = 32'h0000_4500;
        e = ref_block(b, SN, SH, OW, c);
        pulse(b);
        packet_done();
        vectors++;
        if (bus.tx_data !== 64'h0 || bus.underrun !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_underrun: got tx=%h und=%b want 0 1", bus.tx_data, bus.underrun);
        end
        wait_ready("mid_ready");
        packet_done();
        vectors++;
        if (bus.tx_data !== e) begin
            miscompares++;
            $display("FAIL mid_deliver: got %h want %h", bus.tx_data, e);
        end
    endtask

    task automatic test_overrun();
        blk_t a, b;
        int   c;
        logic [63:0] e;
        a = '{default: 32'h0};
        b = '{default: 32'h0};
        for (int k = 0; k < SN; k++) begin
            a[k] = gen_sample();
            b[k] = gen_sample();
        end
        e = ref_block(a, SN, SH, OW, c);
        clear_flags();
        pulse(a);
        repeat (4) step();
        pulse(b);
        vectors++;
        if (bus.overrun !== 1'b1 || bus.ready !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_flag: got ovr=%b rdy=%b want 1 1", bus.overrun, bus.ready);
        end
        packet_done();
        vectors++;
        if (bus.tx_data !== e) begin
            miscompares++;
            $display("FAIL overrun_keep_first: got %h want %h", bus.tx_data, e);
        end
    endtask

    task automatic test_back_to_back();
        blk_t a, b;
        int   c;
        logic [63:0] ea, eb;
        a = '{default: 32'h0};
        b = '{default: 32'h0};
        for (int k = 0; k < SN; k++) begin
            a[k] = gen_sample();
            b[k] = gen_sample();
        end
        ea = ref_block(a, SN, SH, OW, c);
        eb = ref_block(b, SN, SH, OW, c);
        clear_flags();
        pulse(a);
        wait_ready("b2b_a");
        for (int k = 0; k < SN; k++) bus.result_data[k*AW +: AW] = b[k];
        bus.result_valid = 1'b1;
        bus.packet_done  = 1'b1;
        step();
        bus.result_valid = 1'b0;
        bus.packet_done  = 1'b0;
        vectors++;
        if (bus.tx_data !== ea || bus.busy !== 1'b1 || bus.overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_swap: got tx=%h busy=%b ovr=%b want %h 1 0",
                     bus.tx_data, bus.busy, bus.overrun, ea);
        end
        wait_ready("b2b_b");
        packet_done();
        vectors++;
        if (bus.tx_data !== eb || bus.overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second: got tx=%h ovr=%b want %h 0", bus.tx_data, bus.overrun, eb);
        end
    endtask

    task automatic test_random();
        blk_t b;
        int   c;
        int   exp_sat;
        logic [63:0] e;
        clear_flags();
        exp_sat = 0;
        b = '{default: 32'h0};
        for (int it = 0; it < 24; it++) begin
            for (int k = 0; k < SN; k++) b[k] = gen_sample();
            e = ref_block(b, SN, SH, OW, c);
            exp_sat = exp_sat + c;
            pulse(b);
            wait_ready("rand_ready");
            repeat ($urandom_range(0, 2)) step();
            packet_done();
            vectors++;
            if (bus.tx_data !== e || bus.sat_count !== 16'(exp_sat)) begin
                miscompares++;
                $display("FAIL rand_%0d: got tx=%h sat=%0d want %h %0d",
                         it, bus.tx_data, bus.sat_count, e, exp_sat);
            end
        end
    endtask

    task automatic test_wide();
        for (int k = 0; k < 8; k++) bus8.result_data[k*32 +: 32] = 32'(k + 1);
        bus8.result_valid = 1'b1;
        step();
        bus8.result_valid = 1'b0;
        repeat (7) step();
        vectors++;
        if (bus8.ready !== 1'b0 || bus8.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wide_t7: got rdy=%b busy=%b want 0 1", bus8.ready, bus8.busy);
        end
        step();
        vectors++;
        if (bus8.ready !== 1'b1) begin
            miscompares++;
            $display("FAIL wide_t8: got rdy=%b want 1", bus8.ready);
        end
        bus8.packet_done = 1'b1;
        step();
        bus8.packet_done = 1'b0;
        vectors++;
        if (bus8.tx_data !== 64'h0102_0304_0506_0708) begin
            miscompares++;
            $display("FAIL wide_tx: got %h want 0102030405060708", bus8.tx_data);
        end
    endtask

    initial begin
        bus.result_valid  = 1'b0;
        bus.result_data   = '0;
        bus.packet_done   = 1'b0;
        bus.clear_flags   = 1'b0;
        bus8.result_valid = 1'b0;
        bus8.result_data  = '0;
        bus8.packet_done  = 1'b0;
        bus8.clear_flags  = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        test_reset();
        test_rounding();
        test_saturation();
        test_underrun_mid_scale();
        test_overrun();
        test_back_to_back();
        test_random();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fir_result_framer.md
Name: fir_result_framer

Overview:
- Downstream stage of the FIR filter.
- Captures each completed block of wide accumulator results, then rounds, scales and saturates each sample to the output width, one sample per clock.
- Packs the scaled samples into an SPI-packet-wide staging word.
- Hands the staged word to the SPI slave's transmit register on each packet boundary.
- Replaces ad-hoc double buffering in the top level and adds overrun/underrun/saturation reporting.

Parameters:
- SAMPLES_NUM, 2, samples per block (1..8).
- ACC_WIDTH, 32, signed width of each FIR result sample.
- OUT_WIDTH, 16, signed width of each transmitted sample (2..ACC_WIDTH).
- SHIFT, 8, arithmetic right-shift applied before saturation (0..ACC_WIDTH-1).
- PACKET_BYTES, 8, SPI packet size in bytes. Requires SAMPLES_NUM*OUT_WIDTH <= PACKET_BYTES*8.

Ports:
- clkIn  in  1  system clock; all logic on rising edge.
- resetIn  in  1  asynchronous, active-high reset.
- resultValidIn  in  1  single-cycle pulse: resultDataIn holds a complete block.
- resultDataIn  in  ACC_WIDTH*SAMPLES_NUM  signed samples; sample i = bits [ACC_WIDTH*(i+1)-1 : ACC_WIDTH*i].
- packetDoneIn  in  1  single-cycle pulse at the end of each SPI packet.
- clearFlagsIn  in  1  synchronous clear of overrunOut, underrunOut and satCountOut.
- txDataOut  out  PACKET_BYTES*8  word loaded into the SPI slave transmit path.
- readyOut  out  1  staging word complete and awaiting packetDoneIn.
- busyOut  out  1  scaling in progress.
- overrunOut  out  1  sticky: a result block was dropped.
- underrunOut  out  1  sticky: a packet boundary arrived with no staged word.
- satCountOut  out  16  number of saturated samples; holds at 0xFFFF.

Behaviour:
- Reset (async, resetIn=1): state IDLE; input register, staging word, txDataOut, all flags and satCountOut = 0. A reset asserted mid-scale abandons the block; no partial data survives.
- FSM states: IDLE, SCALE, READY.
- IDLE + resultValidIn: capture resultDataIn, clear the sample index, go to SCALE.
- SCALE processes sample index k on each edge, k = 0..SAMPLES_NUM-1:
  - Compute r = (s + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) in ACC_WIDTH+1 bits, so there is no wrap.
  - Compute q = r >>> SHIFT.
  - Saturate q to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. Each clipped sample increments satCountOut by 1 unless it is at 0xFFFF.
  - Sample k is written to staging bits [P-1-k*OUT_WIDTH -: OUT_WIDTH], where P = PACKET_BYTES*8. Sample 0 sits in the MSBs and is transmitted first. Unused LSBs are 0.
  - After k = SAMPLES_NUM-1 the FSM goes to READY.
- Timing: pulse sampled at edge t → busyOut high from t to t+SAMPLES_NUM → readyOut high from edge t+SAMPLES_NUM.
- packetDoneIn while in READY: txDataOut <= staging; go to IDLE. If resultValidIn is high in the same cycle, capture the new block and go directly to SCALE. No overrun is flagged in that case.
- packetDoneIn while in IDLE or SCALE:
  - txDataOut <= 0; underrunOut <= 1.
  - An in-progress scale continues unaffected, and its result is delivered at the next packetDoneIn.
- resultValidIn in SCALE, or in READY without packetDoneIn: the block is dropped, overrunOut <= 1, and staging is unchanged.
- clearFlagsIn: clears the flags and counter on the next edge. If a flag-setting event occurs in the same cycle, the event wins.
- txDataOut changes only on packetDoneIn edges, or on reset.

Test Plan (defaults unless stated):
1. Reset: assert resetIn mid-SCALE → all outputs 0 and state IDLE. The next packetDoneIn gives txDataOut=0 and underrunOut=1.
2. Rounding, positive and negative samples:
   - Stimulus: s0=0x0000_1280, s1=0xFFFF_FE80 (-384).
   - Scaling: s0 → 0x0013; s1 → (-384+128)>>>8 = -1 → 0xFFFF.
   - Timing: readyOut high 2 cycles after the pulse edge.
   - Result: packetDoneIn → txDataOut=0x0013_FFFF_0000_0000.
3. Saturation: s0=0x7FFF_FFFF → 0x7FFF; s1=0x8000_0000 → 0x8000; satCountOut=2. A further block with 0 clipped samples leaves the count at 2; clearFlagsIn → 0.
4. Overrun: two resultValidIn pulses 5 cycles apart, no packetDoneIn → overrunOut=1. The staged word equals the first block, and packetDoneIn transmits the first block.
5. Simultaneous events: in READY, packetDoneIn and resultValidIn in the same cycle → txDataOut gets the old staging, the new block enters SCALE, and overrunOut stays 0.
6. SAMPLES_NUM=8, OUT_WIDTH=8, SHIFT=0: samples 1..8 → txDataOut=0x0102_0304_0506_0708, readyOut after 8 cycles.
